rf_wport_arbiter: RTL and testbench

- Shares the register file's single write port (we/waddr/wdata) between two writeback requesters.
  - Requester A: execute-stage ALU results.
  - Requester B: memory loads and multi-cycle MUL/DIV results.
- Round-robin arbitration with a valid/grant handshake.
- Registered write-port outputs drive the register file directly.
- Also keeps saturating commit and conflict statistics for debug.

---
 rtl/rf_wport_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and LSU/MDU writeback.
// Optional same-cycle forwarding from the registered port is enabled by RF_WPORT_BYPASS_EN.
module rf_wport_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          req_a,
    input  logic [AW-1:0] waddr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    input  logic          req_b,
    input  logic [AW-1:0] waddr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
`ifdef RF_WPORT_BYPASS_EN
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          fwd1_hit,
    output logic          fwd2_hit,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [CW-1:0] commit_cnt,
    output logic [CW-1:0] conflict_cnt
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t          pri;
    pri_t          pri_nxt;
    logic          we_nxt;
    logic [AW-1:0] waddr_nxt;
    logic [DW-1:0] wdata_nxt;
    logic          conflict;
    logic          open;

    assign open     = ~rst & ~hold;
    assign conflict = req_a & req_b & open;

    always_ff @(posedge clk) begin
        if (rst) begin
            pri <= PRI_A;
        end else begin
            pri <= pri_nxt;
        end
    end

    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        pri_nxt   = pri;
        we_nxt    = 1'b0;
        waddr_nxt = rf_waddr;
        wdata_nxt = rf_wdata;
        if (open) begin
            gnt_a = req_a & ((pri == PRI_A) | ~req_b);
            gnt_b = req_b & ((pri == PRI_B) | ~req_a);
        end
        unique case (1'b1)
            gnt_a: begin
                pri_nxt = PRI_B;
                // x0 writes are consumed but never reach the file
                if (waddr_a != '0) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = waddr_a;
                    wdata_nxt = wdata_a;
                end
            end
            gnt_b: begin
                pri_nxt = PRI_A;
                if (waddr_b != '0) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = waddr_b;
                    wdata_nxt = wdata_b;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= we_nxt;
            rf_waddr <= waddr_nxt;
            rf_wdata <= wdata_nxt;
        end
    end

    // counters saturate so a long debug run never wraps to a misleading value
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (we_nxt && (commit_cnt != '1)) begin
                commit_cnt <= commit_cnt + 1'b1;
            end
            if (conflict && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

`ifdef RF_WPORT_BYPASS_EN
    assign fwd1_hit = rf_we & (rf_waddr == raddr1) & (raddr1 != '0);
    assign fwd2_hit = rf_we & (rf_waddr == raddr2) & (raddr2 != '0);
    assign fwd_data = rf_wdata;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: a reference model predicts grants and
// queued writes; a negedge monitor pops and compares every port write.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        req_a = 1'b0;
    logic [4:0]  waddr_a = '0;
    logic [31:0] wdata_a = '0;
    logic        gnt_a;
    logic        req_b = 1'b0;
    logic [4:0]  waddr_b = '0;
    logic [31:0] wdata_b = '0;
    logic        gnt_b;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] commit_cnt;
    logic [15:0] conflict_cnt;
`ifdef RF_WPORT_BYPASS_EN
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    rf_wport_arbiter #(.AW(5), .DW(32), .CW(16)) dut (
        .clk(clk),
        .rst(rst),
        .hold(hold),
        .req_a(req_a),
        .waddr_a(waddr_a),
        .wdata_a(wdata_a),
        .gnt_a(gnt_a),
        .req_b(req_b),
        .waddr_b(waddr_b),
        .wdata_b(wdata_b),
        .gnt_b(gnt_b),
`ifdef RF_WPORT_BYPASS_EN
        .raddr1(raddr1),
        .raddr2(raddr2),
        .fwd1_hit(fwd1_hit),
        .fwd2_hit(fwd2_hit),
        .fwd_data(fwd_data),
`endif
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .commit_cnt(commit_cnt),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        int          due;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        mpri = 1'b0;
    int          mcommit = 0;
    int          mconf = 0;
    logic [4:0]  last_a = '0;
    logic [31:0] last_d = '0;
    logic        ga_seen;
    logic        gb_seen;
    logic [31:0] shadow [32];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb.size() == 0 || sb[0].due != cyc) begin
                chk("spurious_we", rf_we, 1'b0);
            end else begin
                chk("wr_addr", rf_waddr, sb[0].a);
                chk("wr_data", rf_wdata, sb[0].d);
                shadow[rf_waddr] = rf_wdata;
                void'(sb.pop_front());
            end
        end else if (sb.size() != 0 && sb[0].due == cyc) begin
            chk("missing_we", rf_we, 1'b1);
            void'(sb.pop_front());
        end
    end

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.due = cyc + 1;
        w.a   = a;
        w.d   = d;
        sb.push_back(w);
        mcommit++;
        last_a = a;
        last_d = d;
    endtask

    task automatic cycle(input logic ra, input logic [4:0] aa,
                         input logic [31:0] da, input logic rb,
                         input logic [4:0] ab, input logic [31:0] db,
                         input logic h, input logic r);
        logic ega;
        logic egb;
        @(posedge clk);
        #1;
        req_a = ra; waddr_a = aa; wdata_a = da;
        req_b = rb; waddr_b = ab; wdata_b = db;
        hold = h; rst = r;
        @(negedge clk);
        ega = !r && !h && ra && (!mpri || !rb);
        egb = !r && !h && rb && (mpri || !ra);
        chk("gnt_a", gnt_a, ega);
        chk("gnt_b", gnt_b, egb);
        ga_seen = ega;
        gb_seen = egb;
        if (r) begin
            mpri = 1'b0;
            mcommit = 0;
            mconf = 0;
            last_a = '0;
            last_d = '0;
        end else begin
            if (ra && rb && !h) mconf++;
            if (ega) begin
                mpri = 1'b1;
                if (aa != 0) push(aa, da);
            end else if (egb) begin
                mpri = 1'b0;
                if (ab != 0) push(ab, db);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_cnt();
        chk("commit_cnt", commit_cnt, mcommit);
        chk("conflict_cnt", conflict_cnt, mconf);
    endtask

    logic        pa, pb, rh;
    logic [4:0]  fa_a, fb_a;
    logic [31:0] fa_d, fb_d;

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        req_a = 1'b1;
        req_b = 1'b1;
        cycle(1, 1, 32'h1, 1, 2, 32'h2, 0, 1);
        cycle(1, 1, 32'h1, 1, 2, 32'h2, 0, 1);
        idle(1);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk_cnt();

        for (int i = 0; i < 4; i++)
            cycle(1, 3, 32'h11, 1, 3, 32'h22, 0, 0);
        idle(2);
        chk_cnt();
        chk("reg3_final", shadow[3], 32'h22);

        cycle(0, 0, 0, 1, 0, 32'h55, 0, 0);
        idle(2);
        chk_cnt();
        chk("x0_keep_addr", rf_waddr, last_a);
        chk("x0_keep_data", rf_wdata, last_d);

        cycle(1, 9, 32'h99, 1, 10, 32'haa, 0, 0);
        cycle(0, 0, 0, 1, 10, 32'haa, 0, 0);
        idle(1);

        cycle(1, 5, 32'hdeadbeef, 0, 0, 0, 0, 0);
        idle(2);
        chk_cnt();

        for (int i = 0; i < 3; i++)
            cycle(1, 6, 32'h66, 0, 0, 0, 1, 0);
        cycle(1, 6, 32'h66, 0, 0, 0, 0, 0);
        idle(2);
        chk_cnt();
        chk("reg6", shadow[6], 32'h66);

`ifdef RF_WPORT_BYPASS_EN
        cycle(1, 7, 32'h1234, 0, 0, 0, 0, 0);
        raddr1 = 5'd7;
        raddr2 = 5'd0;
        idle(1);
        chk("fwd1_hit", fwd1_hit, 1'b1);
        chk("fwd2_hit", fwd2_hit, 1'b0);
        chk("fwd_data", fwd_data, 32'h1234);
        idle(1);
        chk("fwd1_idle", fwd1_hit, 1'b0);
`endif

        pa = 1'b0;
        pb = 1'b0;
        fa_a = '0; fb_a = '0; fa_d = '0; fb_d = '0;
        for (int i = 0; i < 80; i++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1'b1;
                fa_a = 5'($urandom_range(0, 31));
                fa_d = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1;
                fb_a = 5'($urandom_range(0, 31));
                fb_d = $urandom;
            end
            rh = ($urandom_range(0, 5) == 0);
            cycle(pa, fa_a, fa_d, pb, fb_a, fb_d, rh, 0);
            if (ga_seen) pa = 1'b0;
            if (gb_seen) pb = 1'b0;
        end
        idle(3);
        chk_cnt();
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
